// File: rtl/display_pkg.sv
// Shared constants and types for the display scan path and its BCD helpers.
package display_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam logic [3:0] AN_ALL_OFF = 4'b1111;

  typedef logic [3:0] bcd_t;

  function automatic logic bcd_valid(input bcd_t nibble);
    return (nibble <= BCD_MAX);
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running prescaler: tick is high during the last of every DIV cycles.
module scan_prescaler #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  // Keep at least one bit so DIV=1 still elaborates; the count then stays 0.
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/display_scan_mux.sv
// Four-digit multiplexed BCD scanner with leading-zero blanking and load validation.
module display_scan_mux
  import display_pkg::*;
#(
  parameter int DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [3:0]  bcd,
  output logic [3:0]  an,
  output logic        blank,
  output logic        frame_done,
  output logic        load_err
);

  function automatic logic word_valid(input logic [15:0] w);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (!bcd_valid(w[i*4 +: 4])) ok = 1'b0;
    return ok;
  endfunction

  function automatic bcd_t digit_sel(input logic [15:0] w, input logic [1:0] i);
    case (i)
      2'd0:    return w[3:0];
      2'd1:    return w[7:4];
      2'd2:    return w[11:8];
      default: return w[15:12];
    endcase
  endfunction

  // A digit is blanked only when it and every digit to its left are zero.
  function automatic logic lz_blank(input logic [15:0] w, input logic [1:0] i,
                                    input logic en);
    case (i)
      2'd0:    return 1'b0;
      2'd1:    return en && (w[15:4] == 12'h000);
      2'd2:    return en && (w[15:8] == 8'h00);
      default: return en && (w[15:12] == 4'h0);
    endcase
  endfunction

  logic        tick;
  logic [1:0]  idx;
  logic [15:0] shadow;
  logic [1:0]  idx_nx;
  logic [15:0] shadow_nx;
  logic        load_ok;
  logic        blank_nx;

  scan_prescaler #(.DIV(DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Outputs are derived from next-state values so they move on the same edge as idx/shadow.
  always_comb begin
    load_ok   = word_valid(digits_in);
    idx_nx    = tick ? idx + 2'd1 : idx;
    shadow_nx = (load && load_ok) ? digits_in : shadow;
    blank_nx  = lz_blank(shadow_nx, idx_nx, blank_lz);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= 2'd0;
      shadow     <= 16'h0000;
      bcd        <= 4'd0;
      an         <= 4'b1110;
      blank      <= 1'b0;
      frame_done <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      idx        <= idx_nx;
      shadow     <= shadow_nx;
      bcd        <= digit_sel(shadow_nx, idx_nx);
      an         <= blank_nx ? AN_ALL_OFF : ~(4'b0001 << idx_nx);
      blank      <= blank_nx;
      frame_done <= tick && (idx == 2'd3);
      load_err   <= load && !load_ok;
    end
  end

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux with DIV=4 and hand-computed expectations.
module tb_display_scan_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] digits_in = 16'h0000;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  bcd;
  logic [3:0]  an;
  logic        blank;
  logic        frame_done;
  logic        load_err;

  int vectors = 0;
  int errors  = 0;

  display_scan_mux #(.DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .digits_in  (digits_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .bcd        (bcd),
    .an         (an),
    .blank      (blank),
    .frame_done (frame_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] e_bcd, input logic [3:0] e_an,
                         input logic e_blank);
    chk({tag, ".bcd"}, {12'h0, bcd}, {12'h0, e_bcd});
    chk({tag, ".an"}, {12'h0, an}, {12'h0, e_an});
    chk({tag, ".blank"}, {15'h0, blank}, {15'h0, e_blank});
  endtask

  initial begin
    // Asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1;
    chk_out("rst_async", 4'd0, 4'b1110, 1'b0);
    chk("rst_async.frame_done", {15'h0, frame_done}, 16'h0);
    chk("rst_async.load_err", {15'h0, load_err}, 16'h0);
    step(2);

    // Basic scan of 1234
    rst = 1'b0; load = 1'b1; digits_in = 16'h1234;
    step(1);                                   // E1
    load = 1'b0;
    chk_out("scan_d0", 4'd4, 4'b1110, 1'b0);
    step(2);                                   // E3
    chk_out("scan_d0_hold", 4'd4, 4'b1110, 1'b0);
    step(1);                                   // E4
    chk_out("scan_d1", 4'd3, 4'b1101, 1'b0);
    step(4);                                   // E8
    chk_out("scan_d2", 4'd2, 4'b1011, 1'b0);
    step(4);                                   // E12
    chk_out("scan_d3", 4'd1, 4'b0111, 1'b0);
    chk("scan_d3.frame_done", {15'h0, frame_done}, 16'h0);
    step(4);                                   // E16
    chk_out("scan_wrap", 4'd4, 4'b1110, 1'b0);
    chk("scan_wrap.frame_done", {15'h0, frame_done}, 16'h1);
    step(1);                                   // E17
    chk("scan_after.frame_done", {15'h0, frame_done}, 16'h0);

    // Leading-zero blanking on 0042
    load = 1'b1; digits_in = 16'h0042; blank_lz = 1'b1;
    step(1);                                   // E18
    load = 1'b0;
    chk_out("lz_d0", 4'd2, 4'b1110, 1'b0);
    step(2);                                   // E20
    chk_out("lz_d1", 4'd4, 4'b1101, 1'b0);
    step(4);                                   // E24
    chk_out("lz_d2", 4'd0, 4'b1111, 1'b1);
    step(4);                                   // E28
    chk_out("lz_d3", 4'd0, 4'b1111, 1'b1);
    step(4);                                   // E32
    chk_out("lz_wrap", 4'd2, 4'b1110, 1'b0);
    chk("lz_wrap.frame_done", {15'h0, frame_done}, 16'h1);
    load = 1'b1; digits_in = 16'h0000;
    step(1);                                   // E33
    load = 1'b0;
    chk_out("zero_d0", 4'd0, 4'b1110, 1'b0);
    step(3);                                   // E36
    chk_out("zero_d1", 4'd0, 4'b1111, 1'b1);
    blank_lz = 1'b0;
    step(1);                                   // E37
    chk_out("lz_off_d1", 4'd0, 4'b1101, 1'b0);

    // Rejected load
    load = 1'b1; digits_in = 16'h1234;
    step(1);                                   // E38
    chk_out("rej_pre", 4'd3, 4'b1101, 1'b0);
    chk("rej_pre.load_err", {15'h0, load_err}, 16'h0);
    digits_in = 16'h12A4;
    step(1);                                   // E39
    load = 1'b0;
    chk("rej.load_err", {15'h0, load_err}, 16'h1);
    chk_out("rej_keep", 4'd3, 4'b1101, 1'b0);
    step(1);                                   // E40
    chk("rej_after.load_err", {15'h0, load_err}, 16'h0);
    chk_out("rej_d2", 4'd2, 4'b1011, 1'b0);
    step(3);                                   // E43
    load = 1'b1; digits_in = 16'h9F99;
    step(1);                                   // E44: rejected load with tick
    load = 1'b0;
    chk("rej_tick.load_err", {15'h0, load_err}, 16'h1);
    chk_out("rej_tick", 4'd1, 4'b0111, 1'b0);
    step(4);                                   // E48
    chk("frame2.frame_done", {15'h0, frame_done}, 16'h1);
    chk_out("frame2", 4'd4, 4'b1110, 1'b0);

    // Simultaneous load and tick while idx=0
    step(3);                                   // E51
    load = 1'b1; digits_in = 16'h5678;
    step(1);                                   // E52
    load = 1'b0;
    chk_out("ld_tick", 4'd7, 4'b1101, 1'b0);
    chk("ld_tick.load_err", {15'h0, load_err}, 16'h0);
    step(5);                                   // E57
    chk_out("mid_d2", 4'd6, 4'b1011, 1'b0);

    // Reset mid-scan, then timing of the first slot change after release
    #2 rst = 1'b1;
    #1;
    chk_out("rst_mid", 4'd0, 4'b1110, 1'b0);
    step(1);
    rst = 1'b0;
    step(3);
    chk_out("rel_hold", 4'd0, 4'b1110, 1'b0);
    step(1);
    chk_out("rel_d1", 4'd0, 4'b1101, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/display_scan_mux.md
# display_scan_mux

Four-digit time-multiplexed scanner sitting directly upstream of `seven_segment`. Captures a 16-bit packed BCD word and cycles through its digits at a programmable refresh rate. Drives one BCD nibble into the `seven_segment` decoder's `bcd` input and an active-low digit-enable vector to the display anodes. Optional leading-zero blanking and BCD validity checking on load.

## Interface
Parameters:
- `DIV`, 50000, clocks per digit slot (refresh tick period); legal range `DIV >= 1`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `digits_in`  in  16  packed BCD; `[3:0]` is digit0 (rightmost), `[15:12]` is digit3.
- `load`  in  1  capture `digits_in` into the shadow register this cycle.
- `blank_lz`  in  1  leading-zero blanking enable; level-sensitive, evaluated every cycle.
- `bcd`  out  4  current digit value, to `seven_segment.bcd`.
- `an`  out  4  active-low digit enable; bit i low means digit i is lit.
- `blank`  out  1  high while the current slot is suppressed.
- `frame_done`  out  1  one-cycle pulse on digit index wrap 3->0.
- `load_err`  out  1  one-cycle pulse when a load is rejected.

## Operation
- **Prescaler** counts 0..DIV-1 and wraps. `tick` is asserted when the count equals DIV-1. With DIV=1, `tick` is asserted every cycle.
- **Digit index** `idx` (2 bits) increments on `tick` and wraps modulo 4.
- **Load:**
  - When `load` is high and every nibble of `digits_in` is <= 9, the shadow register takes `digits_in`.
  - If any nibble is > 9, the shadow register is unchanged and `load_err` pulses for one cycle.
  - `load` is honoured every cycle and has no handshake.
- **Blanking:**
  - Digit i (for i = 1..3) is blanked when `blank_lz`=1 and all shadow digits i..3 are zero.
  - Digit0 is never blanked, so all-zero data shows "0".
  - For a blanked slot, `an` = 4'b1111 and `blank` = 1. `bcd` still carries the shadow nibble (0).
- **Output mapping:**
  - `bcd` = shadow[idx].
  - `an` = ~(1 << idx), unless the slot is blanked.
- **Simultaneous load and tick:** both take effect. Outputs show the new index with the new data.
- **Rejected load coinciding with tick:** the index advances and the old data is displayed.

## Timing
- All outputs are registered and computed from next-state values. They change on the same edge that updates `idx` or the shadow register.
- Latency: `load` sampled at edge k appears on `bcd`/`an` after edge k (one cycle). `load_err` is high for the cycle following edge k.
- `blank_lz` change sampled at edge k is reflected after edge k.
- Each digit slot lasts exactly DIV cycles. A full frame is 4*DIV cycles.
- `frame_done` is high for exactly one cycle, coincident with the slot in which `idx` becomes 0.
- Reset values, applied asynchronously and immediately:
  - prescaler 0, `idx` 0, shadow 16'h0000
  - `bcd` 4'd0, `an` 4'b1110, `blank` 0
  - `frame_done` 0, `load_err` 0
- Reset mid-scan aborts the slot. The first tick after release occurs DIV cycles later.

## Structure
- Shared package `display_pkg`:
  - `NUM_DIGITS` = 4
  - `BCD_MAX` = 4'd9
  - `AN_ALL_OFF` = 4'b1111
  - typedef `bcd_t` (4-bit)
  - function `bcd_valid(nibble)`
- One sub-module, `scan_prescaler` (parameter DIV; ports `clk`, `rst`, `tick`). It is reused by later blink/refresh logic.
- Top level holds the index, shadow register, validity check, blanking logic and output registers.

## Test plan
All scenarios use DIV=4.
- **Reset:** assert `rst` -> `bcd`=0, `an`=4'b1110, `blank`=0, `frame_done`=0, `load_err`=0, asynchronously without waiting for a clock edge.
- **Basic scan:** load 16'h1234 with `blank_lz`=0 -> `bcd` steps 4,3,2,1, each held for 4 cycles, with `an` = 1110, 1101, 1011, 0111. `frame_done` pulses once per 16 cycles as `idx` returns to 0.
- **Leading-zero blanking:** load 16'h0042 with `blank_lz`=1 -> slots 3 and 2 give `an`=1111, `blank`=1; slots 1 and 0 show 4 and 2. Then load 16'h0000 -> only digit0 is lit, `bcd`=0.
- **Rejected load:** load 16'h1234, then load 16'h12A4 -> `load_err` is high for 1 cycle and the display continues to show 1234.
- **Simultaneous load and tick:** load 16'h5678 on the cycle `tick` fires while `idx`=0 -> next cycle `idx`=1 and `bcd`=7.
- **Reset mid-scan:** assert `rst` while `idx`=2 -> immediately `an`=1110 and `bcd`=0; the next slot change occurs 4 cycles after release.
